// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline-control definitions: forward-select codes and the
// in-flight instruction slot record used by the hazard unit.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    // EX-stage operand Mux3 select codes; 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_sel_e;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } pipe_slot_t;

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Compares one pipeline slot against one ID source operand.
// The match is reported split by producer kind (ALU result vs load) so
// the caller can apply the load-use and forwarding rules directly.
module fwd_match
    import core_pkg::*;
(
    input  pipe_slot_t            slot_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  uses_i,
    output logic                  alu_match_o,
    output logic                  load_match_o
);

    logic match;

    // x0 is never a real producer, so rd==0 never matches.
    always_comb begin
        match        = slot_i.valid & slot_i.reg_write & (slot_i.rd != '0) &
                       (slot_i.rd == rs_i) & uses_i;
        alu_match_o  = match & ~slot_i.mem_read;
        load_match_o = match & slot_i.mem_read;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding / hazard control for the 5-stage RV32I core.
// Tracks in-flight destinations, drives the registered EX operand
// forward selects, stalls IF/ID on load-use and bubbles EX on flush.
module fwd_hazard_unit #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
);

    import core_pkg::*;

    localparam int unsigned CNT_W = $clog2(STALL_CYCLES) + 1;

    // Only the EX and MEM occupants are held: a producer in WB while its
    // consumer sits in ID is served by the write-first register file, so
    // the WB occupant never influences any output.
    pipe_slot_t       ex_q, ex_d;
    pipe_slot_t       mem_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fwd_sel_e         fwd_a_q, fwd_a_d;
    fwd_sel_e         fwd_b_q, fwd_b_d;

    logic ex_alu_a, ex_load_a, ex_alu_b, ex_load_b;
    logic mem_alu_a, mem_load_a, mem_alu_b, mem_load_b;
    logic detect;
    logic stall_int;
    logic bubble_int;

    fwd_match u_match_ex_a (
        .slot_i       (ex_q),
        .rs_i         (id_rs1),
        .uses_i       (id_uses_rs1),
        .alu_match_o  (ex_alu_a),
        .load_match_o (ex_load_a)
    );

    fwd_match u_match_ex_b (
        .slot_i       (ex_q),
        .rs_i         (id_rs2),
        .uses_i       (id_uses_rs2),
        .alu_match_o  (ex_alu_b),
        .load_match_o (ex_load_b)
    );

    fwd_match u_match_mem_a (
        .slot_i       (mem_q),
        .rs_i         (id_rs1),
        .uses_i       (id_uses_rs1),
        .alu_match_o  (mem_alu_a),
        .load_match_o (mem_load_a)
    );

    fwd_match u_match_mem_b (
        .slot_i       (mem_q),
        .rs_i         (id_rs2),
        .uses_i       (id_uses_rs2),
        .alu_match_o  (mem_alu_b),
        .load_match_o (mem_load_b)
    );

    // Load-use detection and stall/bubble generation; flush overrides stall.
    always_comb begin
        detect     = id_valid & (ex_load_a | ex_load_b);
        stall_int  = (detect | (cnt_q != '0)) & ~flush;
        bubble_int = stall_int | flush;
    end

    // Slot, counter and select next-state.
    always_comb begin
        ex_d    = '0;
        cnt_d   = cnt_q;
        fwd_a_d = FWD_REGFILE;
        fwd_b_d = FWD_REGFILE;

        if (!bubble_int) begin
            ex_d.valid     = id_valid;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;

            // Youngest producer wins: EX ALU result, then anything in MEM.
            if (ex_alu_a) begin
                fwd_a_d = FWD_MEM;
            end else if (mem_alu_a | mem_load_a) begin
                fwd_a_d = FWD_WB;
            end

            if (ex_alu_b) begin
                fwd_b_d = FWD_MEM;
            end else if (mem_alu_b | mem_load_b) begin
                fwd_b_d = FWD_WB;
            end
        end

        if (flush) begin
            cnt_d = '0;
        end else if (detect) begin
            cnt_d = CNT_W'(STALL_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pipeline slot shift, stall counter and registered selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
        end else begin
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // ex_bubble is held low in reset even if flush is presented then.
    always_comb begin
        stall     = stall_int;
        ex_bubble = bubble_int & rst_n;
        fwd_a_sel = fwd_a_q;
        fwd_b_sel = fwd_b_q;
    end

endmodule
